// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration sequencer
// and its preset table.
package mmcm_drp_pkg;

  localparam int unsigned DRP_AW = 7;
  localparam int unsigned DRP_DW = 16;

  typedef enum logic [3:0] {
    IDLE,
    RST_ASSERT,
    FETCH,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    RST_RELEASE,
    LOCK_WAIT,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DRDY = 2'd1,
    ERR_LOCK = 2'd2
  } err_t;

  // Mask bit set keeps the bit read back from the MMCM.
  function automatic logic [DRP_DW-1:0] drp_merge(
    input logic [DRP_DW-1:0] rd,
    input logic [DRP_DW-1:0] mask,
    input logic [DRP_DW-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_cfg_rom.sv
// Registered preset table, 1-cycle latency from tbl_idx. Entries not listed
// rewrite the power register with a full keep-mask, i.e. leave it untouched.
module mmcm_drp_cfg_rom
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned IDX_W = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [SEL_W+IDX_W-1:0] tbl_idx,
  output logic [DRP_AW-1:0]      tbl_addr,
  output logic [DRP_DW-1:0]      tbl_mask,
  output logic [DRP_DW-1:0]      tbl_data
);

  logic [SEL_W-1:0]  sel;
  logic [IDX_W-1:0]  entry;
  logic [DRP_AW-1:0] rom_addr;
  logic [DRP_DW-1:0] rom_mask;
  logic [DRP_DW-1:0] rom_data;

  assign {sel, entry} = tbl_idx;

  always_comb begin
    rom_addr = 7'h28;
    rom_mask = '1;
    rom_data = '0;
    case (sel)
      SEL_W'(0): begin
        if (entry == IDX_W'(0)) begin
          rom_addr = 7'h08; rom_mask = 16'h1000; rom_data = 16'h0083;
        end else if (entry == IDX_W'(1)) begin
          rom_addr = 7'h09; rom_mask = 16'hFC00; rom_data = 16'h0040;
        end
      end
      SEL_W'(1): begin
        if (entry == IDX_W'(0)) begin
          rom_addr = 7'h08; rom_mask = 16'h1000; rom_data = 16'h0145;
        end else if (entry == IDX_W'(1)) begin
          rom_addr = 7'h09; rom_mask = 16'hFC00; rom_data = 16'h0000;
        end
      end
      SEL_W'(2): begin
        if (entry == IDX_W'(0)) begin
          rom_addr = 7'h0A; rom_mask = 16'h1000; rom_data = 16'h0041;
        end else if (entry == IDX_W'(1)) begin
          rom_addr = 7'h0B; rom_mask = 16'hFC00; rom_data = 16'h0000;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tbl_addr <= '0;
      tbl_mask <= '0;
      tbl_data <= '0;
    end else begin
      tbl_addr <= rom_addr;
      tbl_mask <= rom_mask;
      tbl_data <= rom_data;
    end
  end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Replays one preset as DRP read-modify-write cycles while holding the MMCM
// in reset, then releases it and waits for a stable LOCKED.
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned NUM_REGS     = 23,
  parameter int unsigned IDX_W        = 5,
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 1023,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SEL_W-1:0]       cfg_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [SEL_W-1:0]       cur_sel,
  output logic [SEL_W+IDX_W-1:0] tbl_idx,
  input  logic [DRP_AW-1:0]      tbl_addr,
  input  logic [DRP_DW-1:0]      tbl_mask,
  input  logic [DRP_DW-1:0]      tbl_data,
  output logic [DRP_AW-1:0]      drp_daddr,
  output logic                   drp_den,
  output logic                   drp_dwe,
  output logic [DRP_DW-1:0]      drp_di,
  input  logic [DRP_DW-1:0]      drp_do,
  input  logic                   drp_drdy,
  output logic                   mmcm_rst,
  input  logic                   mmcm_locked
);

  localparam int unsigned MAX_A = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned MAX_W = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel_q, cur_sel_q;
  logic [IDX_W-1:0]  entry_q;
  logic [DRP_AW-1:0] addr_q;
  logic [DRP_DW-1:0] mask_q, data_q, di_q;
  err_t              err_q;
  logic              rst_q, init_q;
  logic [1:0]        lock_ff;
  logic              lock_s, lock_seen;
  logic              last_entry, drdy_hit, lock_hit;

  assign lock_s     = lock_ff[1];
  assign last_entry = (entry_q == IDX_W'(NUM_REGS - 1));
  assign drdy_hit   = (cnt == CNT_W'(DRDY_TIMEOUT - 1));
  assign lock_hit   = (cnt == CNT_W'(LOCK_TIMEOUT - 1));

  assign tbl_idx   = {sel_q, entry_q};
  assign drp_daddr = addr_q;
  assign drp_di    = di_q;
  assign err_code  = err_q;
  assign cur_sel   = cur_sel_q;
  assign mmcm_rst  = rst_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    case (state)
      IDLE:        if (start) state_nxt = RST_ASSERT;
      RST_ASSERT:  if (cnt == CNT_W'(RST_HOLD - 1)) state_nxt = FETCH;
      FETCH:       if (cnt == CNT_W'(1)) state_nxt = RD_REQ;
      RD_REQ: begin
        drp_den   = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        // drdy wins over a timeout hitting in the same cycle
        if (drp_drdy)      state_nxt = WR_REQ;
        else if (drdy_hit) state_nxt = ERROR;
      end
      WR_REQ: begin
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_drdy)      state_nxt = NEXT;
        else if (drdy_hit) state_nxt = ERROR;
      end
      NEXT:        state_nxt = last_entry ? RST_RELEASE : FETCH;
      RST_RELEASE: state_nxt = LOCK_WAIT;
      LOCK_WAIT: begin
        if (lock_s && lock_seen) state_nxt = DONE;
        else if (lock_hit)       state_nxt = ERROR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERROR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sel_q     <= '0;
      cur_sel_q <= '0;
      entry_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      di_q      <= '0;
      err_q     <= ERR_NONE;
      rst_q     <= 1'b1;
      init_q    <= 1'b1;
      lock_ff   <= '0;
      lock_seen <= 1'b0;
    end else begin
      // cnt measures time spent in the current state
      cnt       <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      lock_ff   <= {lock_ff[0], mmcm_locked};
      lock_seen <= (state == LOCK_WAIT) && lock_s;
      init_q    <= 1'b0;
      if (state == IDLE && start) begin
        sel_q   <= cfg_sel;
        entry_q <= '0;
        err_q   <= ERR_NONE;
        rst_q   <= 1'b1;
      end else if (state == RST_RELEASE || init_q) begin
        rst_q   <= 1'b0;
      end
      if (state == FETCH && cnt == CNT_W'(1)) begin
        addr_q <= tbl_addr;
        mask_q <= tbl_mask;
        data_q <= tbl_data;
      end
      if (state == RD_WAIT && drp_drdy) di_q <= drp_merge(drp_do, mask_q, data_q);
      if (state == NEXT && !last_entry) entry_q <= entry_q + 1'b1;
      if (state_nxt == DONE) cur_sel_q <= sel_q;
      if (state_nxt == ERROR) err_q <= (state == LOCK_WAIT) ? ERR_LOCK : ERR_DRDY;
    end
  end

endmodule
